// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU conversion issue/writeback slice.
package fpu_pkg;

  typedef enum logic {
    OP_ITOF = 1'b0,
    OP_FTOI = 1'b1
  } conv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    WB     = 2'd3
  } issue_state_t;

  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpu_unit_mux.sv
// Routes idle/valid/result from the unit picked by op and steers the launch
// pulse to that unit only; extend the case arms when more units appear.
module fpu_unit_mux
  import fpu_pkg::*;
(
  input  conv_op_t    op,
  input  logic        launch,
  input  logic        itof_idle,
  input  logic        itof_valid,
  input  logic [31:0] itof_y,
  input  logic        ftoi_idle,
  input  logic        ftoi_valid,
  input  logic [31:0] ftoi_y,
  output logic        sel_idle,
  output logic        sel_valid,
  output logic [31:0] sel_y,
  output logic        itof_en,
  output logic        ftoi_en
);

  // Select the status and result of the unit addressed by op.
  always_comb begin
    sel_idle  = 1'b0;
    sel_valid = 1'b0;
    sel_y     = FLOAT_ZERO;
    case (op)
      OP_ITOF: begin
        sel_idle  = itof_idle;
        sel_valid = itof_valid;
        sel_y     = itof_y;
      end
      OP_FTOI: begin
        sel_idle  = ftoi_idle;
        sel_valid = ftoi_valid;
        sel_y     = ftoi_y;
      end
      default: begin
        sel_idle  = 1'b0;
        sel_valid = 1'b0;
        sel_y     = FLOAT_ZERO;
      end
    endcase
  end

  assign itof_en = launch && (op == OP_ITOF);
  assign ftoi_en = launch && (op == OP_FTOI);

endmodule

// File: rtl/fpu_conv_issue.sv
// Issues one conversion at a time to itof/ftoi, waits for the result (with a
// hang timeout) and holds it for register writeback until accepted.
module fpu_conv_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_x,
  input  logic [TAG_W-1:0] req_rd,
  output logic             itof_en,
  output logic [31:0]      itof_x,
  input  logic             itof_valid,
  input  logic [31:0]      itof_y,
  input  logic             itof_idle,
  output logic             ftoi_en,
  output logic [31:0]      ftoi_x,
  input  logic             ftoi_valid,
  input  logic [31:0]      ftoi_y,
  input  logic             ftoi_idle,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_rd,
  output logic             busy,
  output logic             err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  issue_state_t     state_r, next_state_s;
  conv_op_t         op_r;
  logic [31:0]      x_r;
  logic [TAG_W-1:0] rd_r;
  logic [31:0]      data_r;
  logic [7:0]       cnt_r;
  logic             err_r;

  logic             sel_idle_s, sel_valid_s;
  logic [31:0]      sel_y_s;
  logic             launch_s, latch_req_s, clr_cnt_s, inc_cnt_s;
  logic             cap_valid_s, cap_timeout_s;

  fpu_unit_mux u_mux (
    .op         (op_r),
    .launch     (launch_s),
    .itof_idle  (itof_idle),
    .itof_valid (itof_valid),
    .itof_y     (itof_y),
    .ftoi_idle  (ftoi_idle),
    .ftoi_valid (ftoi_valid),
    .ftoi_y     (ftoi_y),
    .sel_idle   (sel_idle_s),
    .sel_valid  (sel_valid_s),
    .sel_y      (sel_y_s),
    .itof_en    (itof_en),
    .ftoi_en    (ftoi_en)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode; unit valid only counts while in WAIT.
  always_comb begin
    next_state_s  = state_r;
    req_ready     = 1'b0;
    launch_s      = 1'b0;
    latch_req_s   = 1'b0;
    clr_cnt_s     = 1'b0;
    inc_cnt_s     = 1'b0;
    cap_valid_s   = 1'b0;
    cap_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_req_s  = 1'b1;
          next_state_s = LAUNCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      LAUNCH: begin
        if (sel_idle_s) begin
          launch_s     = 1'b1;
          clr_cnt_s    = 1'b1;
          next_state_s = WAIT;
        end else begin
          next_state_s = LAUNCH;
        end
      end
      WAIT: begin
        if (sel_valid_s) begin
          cap_valid_s  = 1'b1;
          next_state_s = WB;
        end else if (cnt_r == CNT_LAST) begin
          cap_timeout_s = 1'b1;
          next_state_s  = WB;
        end else begin
          inc_cnt_s    = 1'b1;
          next_state_s = WAIT;
        end
      end
      WB: begin
        if (wb_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WB;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Request, counter, result and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_ITOF;
      x_r    <= 32'h0000_0000;
      rd_r   <= {TAG_W{1'b0}};
      data_r <= FLOAT_ZERO;
      cnt_r  <= 8'd0;
      err_r  <= 1'b0;
    end else begin
      if (latch_req_s) begin
        op_r <= conv_op_t'(req_op);
        x_r  <= req_x;
        rd_r <= req_rd;
      end
      if (clr_cnt_s) begin
        cnt_r <= 8'd0;
      end else if (inc_cnt_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (cap_valid_s) begin
        data_r <= sel_y_s;
      end else if (cap_timeout_s) begin
        data_r <= FLOAT_ZERO;
      end
      if (cap_timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign itof_x   = x_r;
  assign ftoi_x   = x_r;
  assign wb_valid = (state_r == WB);
  assign wb_data  = data_r;
  assign wb_rd    = rd_r;
  assign busy     = (state_r != IDLE);
  assign err      = err_r;

endmodule

// File: tb/tb_fpu_conv_issue.sv
// Bench for fpu_conv_issue: stub conversion units plus a cycle-timeline model
// of each request, checked with immediate assertions.
module tb_fpu_conv_issue;

  localparam int TAG_W   = 6;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_op = 1'b0;
  logic [31:0]      req_x = 32'h0;
  logic [TAG_W-1:0] req_rd = '0;
  logic             req_ready;
  logic             itof_en, ftoi_en;
  logic [31:0]      itof_x, ftoi_x;
  logic             itof_valid, ftoi_valid;
  logic [31:0]      itof_y, ftoi_y;
  logic             itof_idle = 1'b1;
  logic             ftoi_idle = 1'b1;
  logic             wb_valid;
  logic             wb_ready = 1'b1;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_rd;
  logic             busy, err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic err_sticky = 1'b0;
  logic hang = 1'b0;
  logic it_stray = 1'b0, ft_stray = 1'b0;
  logic it_pend = 1'b0, ft_pend = 1'b0, it_v = 1'b0, ft_v = 1'b0;
  logic [31:0] it_res = 32'h0, ft_res = 32'h0, it_out = 32'h0, ft_out = 32'h0;

  fpu_conv_issue #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_rd(req_rd),
    .itof_en(itof_en), .itof_x(itof_x), .itof_valid(itof_valid),
    .itof_y(itof_y), .itof_idle(itof_idle),
    .ftoi_en(ftoi_en), .ftoi_x(ftoi_x), .ftoi_valid(ftoi_valid),
    .ftoi_y(ftoi_y), .ftoi_idle(ftoi_idle),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact int32 -> float32 for magnitudes below 2^24.
  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic        s;
    logic [31:0] m;
    int          e;
    if (x == 32'h0) return 32'h0;
    s = x[31];
    m = s ? (32'h0 - x) : x;
    e = 31;
    while (!m[31]) begin
      m = m << 1;
      e = e - 1;
    end
    return {s, 8'(e + 127), m[30:8]};
  endfunction

  // Stand-in transform for the ftoi stub; the DUT only forwards it.
  function automatic logic [31:0] ftoi_stub(input logic [31:0] x);
    return x ^ 32'h5A5A_0F0F;
  endfunction

  // Unit stubs: sample en at an edge, pulse valid for one cycle one cycle later.
  always @(posedge clk) begin
    it_pend <= itof_en;
    it_res  <= i2f(itof_x);
    it_v    <= it_pend && !hang;
    it_out  <= it_res;
    ft_pend <= ftoi_en;
    ft_res  <= ftoi_stub(ftoi_x);
    ft_v    <= ft_pend && !hang;
    ft_out  <= ft_res;
  end

  assign itof_valid = it_v | it_stray;
  assign ftoi_valid = ft_v | ft_stray;
  assign itof_y     = it_out;
  assign ftoi_y     = ft_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request: h = cycles the selected unit reports busy, b = cycles of
  // writeback backpressure. Timeline from accept edge t=0: en at t=h, first
  // WB cycle L = h+3 (or h+1+TIMEOUT when hung), IDLE at L+b+1.
  task automatic run_req(input logic op, input logic [31:0] x, input logic [TAG_W-1:0] rd,
                         input logic [31:0] exp_data, input int h, input int b,
                         input logic hng, input logic keep, output int acc);
    int   last_wb;
    logic exp_err;
    hang      = hng;
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_rd    = rd;
    acc       = 0;
    #1;
    chk("ready_before", req_ready, 1'b1);
    chk("busy_before", busy, 1'b0);
    last_wb = hng ? (h + 1 + TIMEOUT) : (h + 3);
    for (int t = 0; t <= last_wb + b + 1; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) acc = cyc;
      if (t <= last_wb + b) begin
        req_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
        req_op    = 1'($urandom_range(0, 1));
        req_x     = $urandom;
        req_rd    = TAG_W'($urandom);
      end else begin
        req_valid = keep;
      end
      if (t < last_wb) wb_ready = 1'($urandom_range(0, 1));
      else if (t < last_wb + b) wb_ready = 1'b0;
      else wb_ready = 1'b1;
      if (op) begin
        ftoi_idle = (t >= h);
        itof_idle = 1'($urandom_range(0, 1));
        it_stray  = 1'($urandom_range(0, 1));
        ft_stray  = (t <= h || t >= last_wb) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        itof_idle = (t >= h);
        ftoi_idle = 1'($urandom_range(0, 1));
        ft_stray  = 1'($urandom_range(0, 1));
        it_stray  = (t <= h || t >= last_wb) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      exp_err = err_sticky | (hng && t >= last_wb);
      chk("err", err, exp_err);
      if (t <= last_wb + b) begin
        chk("busy", busy, 1'b1);
        chk("req_ready", req_ready, 1'b0);
        chk("itof_en", itof_en, (t == h) && !op);
        chk("ftoi_en", ftoi_en, (t == h) && op);
        chk("itof_x", itof_x, x);
        chk("ftoi_x", ftoi_x, x);
        chk("wb_valid", wb_valid, t >= last_wb);
        if (t >= last_wb) begin
          chk("wb_data", wb_data, exp_data);
          chk("wb_rd", wb_rd, rd);
        end
      end else begin
        chk("busy_after", busy, 1'b0);
        chk("ready_after", req_ready, 1'b1);
        chk("wb_valid_after", wb_valid, 1'b0);
        chk("en_after", {itof_en, ftoi_en}, 2'b00);
      end
    end
    if (hng) err_sticky = 1'b1;
    it_stray  = 1'b0;
    ft_stray  = 1'b0;
    itof_idle = 1'b1;
    ftoi_idle = 1'b1;
    wb_ready  = 1'b1;
    hang      = 1'b0;
  endtask

  initial begin
    int          acc1, acc2, h, b;
    logic        op;
    logic [31:0] x, mag;

    // Reset state, checked while reset is asserted and just after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_en", {itof_en, ftoi_en}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", wb_rd, 6'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);

    // itof -5 -> -5.0f, tag 7.
    run_req(1'b0, 32'hFFFF_FFFB, 6'd7, 32'hC0A0_0000, 0, 0, 1'b0, 1'b0, acc1);

    // Back-to-back with req_valid held: itof 0 then itof 1.
    run_req(1'b0, 32'h0000_0000, 6'd1, 32'h0000_0000, 0, 0, 1'b0, 1'b1, acc1);
    run_req(1'b0, 32'h0000_0001, 6'd2, 32'h3F80_0000, 0, 0, 1'b0, 1'b0, acc2);
    chk("b2b_gap", 64'(acc2 - acc1), 64'd5);

    // Writeback backpressure for 4 cycles on itof 8.
    run_req(1'b0, 32'h0000_0008, 6'd9, 32'h4100_0000, 0, 4, 1'b0, 1'b0, acc1);

    // Busy unit for 3 cycles after accept.
    run_req(1'b0, 32'h0000_0003, 6'd3, 32'h4040_0000, 3, 0, 1'b0, 1'b0, acc1);

    // Randomized requests against the timeline model.
    for (int i = 0; i < 16; i++) begin
      op  = 1'($urandom_range(0, 1));
      mag = 32'($urandom_range(0, 32'h00FF_FFFF));
      x   = op ? $urandom : ($urandom_range(0, 1) ? (32'h0 - mag) : mag);
      h   = $urandom_range(0, 3);
      b   = $urandom_range(0, 3);
      run_req(op, x, TAG_W'($urandom), op ? ftoi_stub(x) : i2f(x), h, b, 1'b0, 1'b0, acc1);
    end

    // Hung ftoi: timeout yields zero data and sticky err.
    run_req(1'b1, 32'h1234_5678, 6'd21, 32'h0, 0, 0, 1'b1, 1'b0, acc1);
    run_req(1'b1, 32'h0BAD_F00D, 6'd22, ftoi_stub(32'h0BAD_F00D), 1, 2, 1'b0, 1'b0, acc1);

    // Reset while waiting on a hung ftoi, then a late valid after release.
    hang      = 1'b1;
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_x     = 32'hCAFE_0001;
    req_rd    = 6'd30;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    err_sticky = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    hang = 1'b0;
    @(posedge clk);
    #1;
    ft_stray = 1'b1;
    @(negedge clk);
    chk("late_valid_busy", busy, 1'b0);
    chk("late_valid_wb", wb_valid, 1'b0);
    @(posedge clk);
    #1;
    ft_stray = 1'b0;
    @(negedge clk);
    chk("post_late_busy", busy, 1'b0);
    chk("post_late_wb", wb_valid, 1'b0);
    chk("post_late_err", err, 1'b0);
    chk("post_late_ready", req_ready, 1'b1);
    chk("post_late_data", wb_data, 32'h0);

    run_req(1'b1, 32'h7777_0000, 6'd5, ftoi_stub(32'h7777_0000), 0, 1, 1'b0, 1'b0, acc1);
    run_req(1'b0, 32'hFFFF_FFF8, 6'd6, 32'hC100_0000, 2, 0, 1'b0, 1'b0, acc1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
